// File: rtl/truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// truth_table_sequencer
//
// Purpose:
//   Sweeps a 4-input combinational stage under test through all 16 input
//   vectors in ascending order. Each vector is held for HOLD_CYCLES clock
//   cycles. On the last cycle of each hold the stage outputs f and g are
//   captured into f_table / g_table. This gives the stage the whole hold
//   window to settle before its value is taken.
//
// Optional feature (macro TT_MISMATCH_CHECK_EN):
//   When defined, every captured {f,g} pair is compared against the expected
//   columns EXP_F / EXP_G. Mismatching vectors are counted in mismatch_cnt,
//   which saturates at 16. err flags a nonzero count. When the macro is
//   undefined, mismatch_cnt and err are tied to 0 and no compare logic exists.
//
// Parameters:
//   HOLD_CYCLES  cycles each vector is held (2..255)
//   EXP_F/EXP_G  expected f / g column, bit n belongs to vector n
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         synchronous active-low reset
//   start         sweep request, only honoured in IDLE
//   a,b,c,d       vector index driven to the stage under test, a = MSB
//   f,g           outputs of the stage under test
//   busy          high while vectors are being driven
//   done          one-cycle pulse when a sweep completes
//   f_table       captured f column
//   g_table       captured g column
//   mismatch_cnt  number of vectors whose captured {f,g} differs from expected
//   err           mismatch_cnt != 0
// -----------------------------------------------------------------------------
module truth_table_sequencer #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [15:0] EXP_F       = 16'h0000,
    parameter logic [15:0] EXP_G       = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    input  logic        g,
    output logic        busy,
    output logic        done,
    output logic [15:0] f_table,
    output logic [15:0] g_table,
    output logic [4:0]  mismatch_cnt,
    output logic        err
);

    // Last value of the hold counter within one vector; this is the capture point.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] f_tab_q, f_tab_d;
    logic [15:0] g_tab_q, g_tab_d;
    logic        capture_s;
    logic        accept_s;

    // State, vector, hold counter and table registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 4'd0;
            hold_q  <= 8'd0;
            f_tab_q <= 16'h0000;
            g_tab_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            f_tab_q <= f_tab_d;
            g_tab_q <= g_tab_d;
        end
    end

    // Next-state logic: accept start, step through the vectors, capture results.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        hold_d    = hold_q;
        f_tab_d   = f_tab_q;
        g_tab_d   = g_tab_q;
        capture_s = 1'b0;
        accept_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // A new sweep starts with cleared tables; vec in IDLE
                    // otherwise keeps the last vector driven.
                    accept_s = 1'b1;
                    state_d  = ST_DRIVE;
                    vec_d    = 4'd0;
                    hold_d   = 8'd0;
                    f_tab_d  = 16'h0000;
                    g_tab_d  = 16'h0000;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (hold_q == HOLD_LAST) begin
                    capture_s       = 1'b1;
                    f_tab_d[vec_q]  = f;
                    g_tab_d[vec_q]  = g;
                    hold_d          = 8'd0;
                    if (vec_q == 4'd15) begin
                        // vec stays at 15 so IDLE keeps showing the final vector.
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef TT_MISMATCH_CHECK_EN
    logic [4:0] mism_q, mism_d;

    // Mismatch counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mism_q <= 5'd0;
        end else begin
            mism_q <= mism_d;
        end
    end

    // Compare each captured pair with the expected columns; saturate at 16.
    always_comb begin
        mism_d = mism_q;
        if (accept_s) begin
            mism_d = 5'd0;
        end else if (capture_s && ({f, g} != {EXP_F[vec_q], EXP_G[vec_q]})
                     && (mism_q != 5'd16)) begin
            mism_d = mism_q + 5'd1;
        end else begin
            mism_d = mism_q;
        end
    end

    assign mismatch_cnt = mism_q;
    assign err          = (mism_q != 5'd0);
`else
    // Compare logic absent: expected columns and capture strobe are not consumed.
    logic unused_cmp_s;
    assign unused_cmp_s = ^{EXP_F, EXP_G, capture_s, accept_s};

    assign mismatch_cnt = 5'd0;
    assign err          = 1'b0;
`endif

    // Outputs are decoded directly from registers.
    assign {a, b, c, d} = vec_q;
    assign busy         = (state_q == ST_DRIVE);
    assign done         = (state_q == ST_DONE);
    assign f_table      = f_tab_q;
    assign g_table      = g_tab_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sequencer
//
// Self-checking bench for truth_table_sequencer with HOLD_CYCLES=4. The stage
// under test is emulated by per-bench truth tables tf/tg (f = tf[vector],
// g = tg[vector]). A pulse mode lets f be high only on one chosen hold cycle,
// so the bench can tell which cycle of the hold window is captured.
// -----------------------------------------------------------------------------
module tb_truth_table_sequencer;

    localparam int          H     = 4;
    localparam logic [15:0] EXP_F = 16'hF000;
    localparam logic [15:0] EXP_G = 16'hEEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        a, b, c, d;
    logic        f, g;
    logic        busy, done;
    logic [15:0] f_table, g_table;
    logic [4:0]  mismatch_cnt;
    logic        err;

    logic [15:0] tf, tg;
    logic        pulse_mode, pulse_f;

    int errors = 0;
    int checks = 0;

    assign f = pulse_mode ? pulse_f : tf[{a, b, c, d}];
    assign g = tg[{a, b, c, d}];

    truth_table_sequencer #(
        .HOLD_CYCLES(H),
        .EXP_F(EXP_F),
        .EXP_G(EXP_G)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .c(c),
        .d(d),
        .f(f),
        .g(g),
        .busy(busy),
        .done(done),
        .f_table(f_table),
        .g_table(g_table),
        .mismatch_cnt(mismatch_cnt),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected mismatch count: vectors where the captured pair differs from EXP.
    function automatic int exp_mism(input logic [15:0] ef, input logic [15:0] eg);
`ifdef TT_MISMATCH_CHECK_EN
        int n;
        n = 0;
        for (int v = 0; v < 16; v++) begin
            if ((ef[v] != EXP_F[v]) || (eg[v] != EXP_G[v])) n++;
        end
        return n;
`else
        return 0;
`endif
    endfunction

    // One full sweep with an optional ignored start pulse at cycle ignore_at.
    task automatic run_sweep(input string name, input int ignore_at);
        int done_at, vec_bad, busy_bad, m;
        logic [15:0] ef, eg;
        ef = tf;
        eg = tg;
        m  = exp_mism(ef, eg);
        done_at  = -1;
        vec_bad  = 0;
        busy_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 16 * H + 4 && done_at < 0; i++) begin
            if ({a, b, c, d} !== 4'((i - 1) / H)) vec_bad++;
            if (busy !== 1'b1) busy_bad++;
            start = (i - 1 == ignore_at) ? 1'b1 : 1'b0;
            tick();
            if (done === 1'b1) done_at = i;
        end
        start = 1'b0;
        checks++;
        if (done_at != 16 * H) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, done_at, 16 * H);
        end
        checks++;
        if (vec_bad != 0) begin
            errors++;
            $display("FAIL %s vector_sequence: %0d bad cycles, want 0", name, vec_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_during_sweep: %0d bad cycles, want 0", name, busy_bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, busy);
        end
        checks++;
        if (f_table !== ef || g_table !== eg) begin
            errors++;
            $display("FAIL %s tables: got f=%h g=%h want f=%h g=%h", name, f_table, g_table, ef, eg);
        end
        checks++;
        if (mismatch_cnt !== 5'(m) || err !== (m != 0)) begin
            errors++;
            $display("FAIL %s mismatch: got cnt=%0d err=%b want cnt=%0d err=%b", name, mismatch_cnt, err, m, (m != 0));
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {a, b, c, d} !== 4'hF || f_table !== ef || g_table !== eg) begin
            errors++;
            $display("FAIL %s idle_after_done: got done=%b busy=%b vec=%h f=%h g=%h want 0 0 f %h %h",
                     name, done, busy, {a, b, c, d}, f_table, g_table, ef, eg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {a, b, c, d} !== 4'h0 || f_table !== 16'h0 ||
            g_table !== 16'h0 || mismatch_cnt !== 5'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b vec=%h f=%h g=%h cnt=%0d err=%b want all 0",
                     busy, done, {a, b, c, d}, f_table, g_table, mismatch_cnt, err);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            vv = 4'(v);
            tf[v] = vv[3] & vv[2];
            tg[v] = vv[1] | vv[0];
        end
        checks++;
        if (tf !== 16'hF000 || tg !== 16'hEEEE) begin
            errors++;
            $display("FAIL model_tables: got %h %h want f000 eeee", tf, tg);
        end
        run_sweep("and_or", -1);
        tf = EXP_F;
        tg = EXP_G;
        run_sweep("exact_expected", -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            tf = 16'($urandom);
            tg = 16'($urandom);
            run_sweep("random_ignored_start", int'($urandom_range(0, 16 * H - 2)));
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        tf = 16'hFFFF;
        tg = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 30; i++) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || {a, b, c, d} !== 4'h0 || f_table !== 16'h0 || g_table !== 16'h0 ||
            mismatch_cnt !== 5'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b vec=%h f=%h g=%h cnt=%0d want 0",
                     busy, {a, b, c, d}, f_table, g_table, mismatch_cnt);
        end
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL aborted_no_done: got %0d active cycles want 0", done_seen);
        end
    endtask

    task automatic test_start_held();
        int done_at;
        done_at = -1;
        tf = 16'hFFFF;
        tg = 16'h5A5A;
        start = 1'b1;
        tick();
        for (int i = 1; i <= 65; i++) begin
            tick();
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        checks++;
        if (done_at != 16 * H || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_start_done: got done_at=%0d busy=%b want %0d 0", done_at, busy, 16 * H);
        end
        tick();
        checks++;
        if (busy !== 1'b1 || f_table !== 16'h0 || g_table !== 16'h0 || {a, b, c, d} !== 4'h0 ||
            mismatch_cnt !== 5'd0) begin
            errors++;
            $display("FAIL held_restart: got busy=%b f=%h g=%h vec=%h cnt=%0d want 1 0 0 0 0",
                     busy, f_table, g_table, {a, b, c, d}, mismatch_cnt);
        end
        start = 1'b0;
        done_at = -1;
        for (int i = 0; i < 100 && done_at < 0; i++) begin
            tick();
            if (done === 1'b1) done_at = i;
        end
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL held_second_done: got none want pulse");
        end
        tick();
    endtask

    task automatic test_capture_point(input int pos, input logic [15:0] want_f);
        tg = 16'($urandom);
        pulse_mode = 1'b1;
        pulse_f = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 16 * H; n++) begin
            pulse_f = ((n / H) == 5 && (n % H) == pos) ? 1'b1 : 1'b0;
            tick();
        end
        checks++;
        if (done !== 1'b1 || f_table !== want_f || g_table !== tg) begin
            errors++;
            $display("FAIL capture_pos%0d: got done=%b f=%h g=%h want 1 %h %h",
                     pos, done, f_table, g_table, want_f, tg);
        end
        pulse_f = 1'b0;
        pulse_mode = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        tf = 16'h0;
        tg = 16'h0;
        pulse_mode = 1'b0;
        pulse_f = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid();
        test_start_held();
        test_capture_point(H - 1, 16'h0020);
        test_capture_point(0, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
